// File: rtl/sfifo_uart_tx.sv
// sfifo_uart_tx: drains a synchronous FIFO and serializes each byte as 8N1.
// All outputs are registered; the FIFO's registered data is latched one cycle after the pop.
module sfifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    output logic       txd,
    output logic       busy,
    output logic       tx_done
);

    localparam int CW = ($clog2(CLKS_PER_BIT) < 1) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          txd_q, txd_d;
    logic          rd_q, rd_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          wrap;

    assign wrap = (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        txd_d   = txd_q;
        rd_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (enable && !fifo_empty) begin
                    state_d = FETCH;
                    rd_d    = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            FETCH: state_d = LATCH;
            // fifo_data became valid at the edge closing FETCH
            LATCH: begin
                shreg_d = fifo_data;
                cnt_d   = '0;
                bit_d   = '0;
                txd_d   = 1'b0;
                state_d = START;
            end
            START: begin
                cnt_d = wrap ? '0 : cnt_q + CW'(1);
                if (wrap) begin
                    txd_d   = shreg_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                cnt_d = wrap ? '0 : cnt_q + CW'(1);
                if (wrap) begin
                    if (bit_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = shreg_q[bit_q + 3'd1];
                    end
                end
            end
            STOP: begin
                cnt_d = wrap ? '0 : cnt_q + CW'(1);
                if (wrap) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            txd_q   <= 1'b1;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            txd_q   <= txd_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign fifo_rd = rd_q;
    assign txd     = txd_q;
    assign busy    = busy_q;
    assign tx_done = done_q;

endmodule

// File: doc/sfifo_uart_tx.md
# sfifo_uart_tx

Drain side of the 16-deep, 8-bit synchronous FIFO: pops bytes whenever the FIFO is non-empty and serializes each byte as an 8N1 UART frame on a single output line. It drives the FIFO `read` strobe and consumes the FIFO's registered read data and `empty` flag. It sits between the FIFO and the chip's serial TX pin.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per UART bit; legal range 2..65535. The baud counter is `$clog2(CLKS_PER_BIT)` bits wide, minimum 1.
- `CLK`  in  1  single system clock, rising-edge.
- `RSTn`  in  1  asynchronous, active-low reset.
- `enable`  in  1  allows a new frame to start; sampled only in IDLE.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_data`  in  8  FIFO registered read data; valid the cycle after `fifo_rd`.
- `fifo_rd`  out  1  FIFO read strobe; registered; one-cycle pulse per byte.
- `txd`  out  1  serial line; idle high; registered.
- `busy`  out  1  high whenever the state is not IDLE.
- `tx_done`  out  1  one-cycle pulse when a stop bit completes.

## Operation
- States: IDLE, FETCH, LATCH, START, DATA, STOP.
- IDLE:
  - `txd`=1.
  - If `enable` && !`fifo_empty` at an edge, go to FETCH and set `fifo_rd`=1.
  - Otherwise stay in IDLE.
- FETCH:
  - `fifo_rd` is high for this cycle only.
  - The FIFO updates `fifo_data` at the closing edge.
  - Go to LATCH.
- LATCH:
  - At the closing edge: shift reg <= `fifo_data`, baud count <= 0, bit index <= 0, `txd` <= 0.
  - Go to START.
- START: `txd`=0 for CLKS_PER_BIT cycles, then go to DATA with `txd` <= shreg[0].
- DATA:
  - Each bit is held for CLKS_PER_BIT cycles, LSB first.
  - After bit 7, `txd` <= 1 and go to STOP.
- STOP: `txd`=1 for CLKS_PER_BIT cycles, then go to IDLE and pulse `tx_done` for one cycle.
- The baud counter runs 0..CLKS_PER_BIT-1 and wraps. The bit index runs 0..7.
- Deasserting `enable` mid-frame has no effect. The frame completes, and no new pop occurs while `enable`=0.
- `fifo_empty` is ignored outside IDLE. Exactly one pop per frame, and no pop while `fifo_empty`=1.
- `fifo_rd` is never asserted outside the FETCH cycle.

## Timing
- Reset values, applied immediately and asynchronously: state=IDLE, `txd`=1, `fifo_rd`=0, `busy`=0, `tx_done`=0, counters 0, shreg 0.
- Reset mid-frame aborts the frame. `txd` returns high without waiting for a clock, and no pop is issued.
- Let E0 be the edge at which IDLE sees `enable` && !`fifo_empty`:
  - `fifo_rd`=1 for cycle E0..E1.
  - `txd` falls at E2.
  - `tx_done` rises at E2+10*CLKS_PER_BIT and falls one cycle later.
- Frame length is exactly 10*CLKS_PER_BIT cycles of START+DATA+STOP.
- Back-to-back frames with a non-empty FIFO: IDLE, FETCH and LATCH add exactly 3 idle-high cycles after the stop bit. Frame period is 10*CLKS_PER_BIT+3.
- `busy` rises at E0 and falls at the edge where `tx_done` rises.

## Test plan
- Reset: hold `RSTn`=0 for 3 cycles with `fifo_empty`=0 and `enable`=1 -> `txd`=1, `fifo_rd`=0, `busy`=0, `tx_done`=0 throughout.
- Single byte 0xA5, CLKS_PER_BIT=4, real FIFO attached -> one `fifo_rd` pulse, `txd` falls 2 cycles after sample.
  - Line sequence in 4-cycle bits: 0,1,0,1,0,0,1,0,1,1.
  - `tx_done` pulses 40 cycles after `txd` falls. FIFO ends `empty`=1.
- Fill FIFO with 16 bytes 0x00..0x0F -> 16 frames, each with 43-cycle period. Bytes arrive in order; exactly 16 `fifo_rd` pulses, none once `empty`=1. FIFO pointer wrap is exercised.
- `enable` dropped at mid-DATA of frame 1 with 2 bytes queued -> frame 1 completes intact and no further `fifo_rd` occurs. Re-asserting `enable` sends byte 2.
- `RSTn` pulsed low during bit 3 of 0x3C -> `txd`=1 immediately and state is IDLE. After release with the FIFO non-empty, the next frame starts cleanly 2 cycles after the first sampling edge.
- CLKS_PER_BIT=2 with byte 0xFF -> start bit 2 cycles, eight high bits of 2 cycles each, stop bit 2 cycles. Total 20 cycles, one `tx_done`.
